burst_target_responder: RTL

- Target-side end of the burst transaction interface: accepts a burst request, then absorbs write beats into, or returns read beats from, a local register-file memory.
- Keeps its own incrementing beat address from the request start address, which mirrors the initiator-side address generation.
- Flags length violations against the shared burst length.
- Sits in the burst-transactions subsystem as the responder for the burst initiator and its address path.

---
 rtl/bt_top_pkg.sv | 17 +
 rtl/burst_target_responder_regfile.sv | 29 ++
 rtl/burst_target_responder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/bt_top_pkg.sv
// Shared constants and types for the burst-transactions subsystem.
// No logic; latency not applicable.
// No handshakes; backpressure not applicable.
package bt_top;

  localparam int ADDR_WIDTH = 16;
  localparam int BURST_LEN  = 8;
  localparam int LEN_WIDTH  = $clog2(BURST_LEN) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } bt_state_e;

endpackage

// File: rtl/burst_target_responder_regfile.sv
// Flop-array register file: DEPTH x DATA_WIDTH, synchronous write, asynchronous read.
// Write lands on the clock edge; read data is combinational from the index.
// No backpressure; a write is taken whenever wr_vld is high.
module bt_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int IDX_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_vld,
  input  logic [IDX_WIDTH-1:0]  wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_dat,
  input  logic [IDX_WIDTH-1:0]  rd_idx,
  output logic [DATA_WIDTH-1:0] rd_dat
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Storage is deliberately not reset; contents survive a responder reset.
  always_ff @(posedge clk) begin
    if (wr_vld) begin
      mem_q[wr_idx] <= wr_dat;
    end
  end

  // Combinational read port.
  assign rd_dat = mem_q[rd_idx];

endmodule

// File: rtl/burst_target_responder.sv
// Burst target: accepts a request, then sinks write beats into or sources read beats from a local register file.
// Read data valid the cycle after accept; done pulses one cycle after the last beat (or after a rejected request).
// Write beats stall on wvalid low, read beats hold stable on rready low; req_ready low outside IDLE.
module burst_target_responder
  import bt_top::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = bt_top::ADDR_WIDTH,
  parameter int BURST_LEN  = bt_top::BURST_LEN
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  input  logic [$clog2(BURST_LEN):0]    req_len,
  input  logic                          wvalid,
  output logic                          wready,
  input  logic [DATA_WIDTH-1:0]         wdata,
  output logic                          rvalid,
  input  logic                          rready,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          rlast,
  output logic                          done,
  output logic                          err
);

  localparam int LW    = $clog2(BURST_LEN) + 1;
  localparam int IDX_W = $clog2(DEPTH);

  bt_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LW-1:0]         count_q, count_d;
  logic [LW-1:0]         len_q, len_d;
  logic                  err_pending_q, err_pending_d;

  logic                  req_ready_c;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rd_dat;
  logic                  len_bad;
  logic                  last_beat;

  assign len_bad   = (req_len == '0) || (req_len > LW'(BURST_LEN));
  assign last_beat = (count_q == (len_q - LW'(1)));

  bt_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_WIDTH  (IDX_W)
  ) u_regfile (
    .clk    (clk),
    .wr_vld (mem_we),
    .wr_idx (addr_q[IDX_W-1:0]),
    .wr_dat (wdata),
    .rd_idx (addr_q[IDX_W-1:0]),
    .rd_dat (mem_rd_dat)
  );

  // Next-state, beat counters and state-gated handshake outputs.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    count_d       = count_q;
    len_d         = len_q;
    err_pending_d = err_pending_q;
    mem_we        = 1'b0;
    req_ready_c   = 1'b0;
    wready        = 1'b0;
    rvalid        = 1'b0;
    rlast         = 1'b0;
    done          = 1'b0;
    err           = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_c = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          count_d = '0;
          len_d   = req_len;
          if (len_bad) begin
            err_pending_d = 1'b1;
            state_d       = RESP;
          end else if (req_write) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      WRITE: begin
        wready = 1'b1;
        if (wvalid) begin
          mem_we  = 1'b1;
          addr_d  = addr_q + ADDR_WIDTH'(1);
          count_d = count_q + LW'(1);
          if (last_beat) begin
            state_d = RESP;
          end
        end
      end
      READ: begin
        rvalid = 1'b1;
        rlast  = last_beat;
        if (rready) begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          count_d = count_q + LW'(1);
          if (last_beat) begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        done          = 1'b1;
        err           = err_pending_q;
        err_pending_d = 1'b0;
        state_d       = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset forces req_ready low even though the FSM already sits in IDLE.
  assign req_ready = req_ready_c & rstn;
  assign rdata     = rvalid ? mem_rd_dat : '0;

  // State and counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      count_q       <= '0;
      len_q         <= '0;
      err_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      count_q       <= count_d;
      len_q         <= len_d;
      err_pending_q <= err_pending_d;
    end
  end

`ifdef SVA_ON
  a_count_in_range : assert property (@(posedge clk) disable iff (!rstn)
    (state_q == WRITE || state_q == READ) |-> (count_q < len_q));
  a_rdata_stable : assert property (@(posedge clk) disable iff (!rstn)
    (rvalid && !rready) |=> $stable(rdata));
  a_err_with_done : assert property (@(posedge clk) disable iff (!rstn)
    err |-> done);
  a_done_pulse : assert property (@(posedge clk) disable iff (!rstn)
    done |=> !done);
`endif

endmodule
